// File: rtl/clint_pkg.sv
// Shared CSR addresses, trap cause codes and mstatus field positions used by the
// core-local interrupt controller.
package clint_pkg;

  localparam int CSR_ADDRESS_WIDTH = 12;

  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_M_EXT_INT = 32'h8000_000B;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Trap entry: stash MIE into MPIE, disable MIE, record M-mode as previous privilege.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt controller: accepts ecall/ebreak/mret/external irq from ID,
// sequences the CSR updates one per cycle while stalling, then redirects IF once.
module clint
  import clint_pkg::*;
#(
  parameter bit MTVEC_VECTORED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [31:0]                  id_pc,
  input  logic                         inst_ecall,
  input  logic                         inst_ebreak,
  input  logic                         inst_mret,
  input  logic                         irq_external,
  input  logic                         ex_csr_we,
  input  logic [31:0]                  csr_mtvec,
  input  logic [31:0]                  csr_mepc,
  input  logic [31:0]                  csr_mstatus,
  input  logic                         global_interrupt_enable,
  output logic                         csr_we_clint,
  output logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr_clint,
  output logic [31:0]                  csr_wdata_clint,
  output logic                         stall_clint,
  output logic                         jump_flag,
  output logic [31:0]                  jump_addr
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MSTATUS = 3'd3,
    W_MRET    = 3'd4,
    JUMP      = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, cause_q;
  logic        ret_q;
  logic        accept;
  logic [31:0] cause_d;
  logic [31:0] trap_target;

  // Trigger held off while EX writes a CSR so we never race its update.
  always_comb begin
    accept = rst_n && (state_q == IDLE) && id_valid && !ex_csr_we &&
             (inst_mret || inst_ecall || inst_ebreak ||
              (irq_external && global_interrupt_enable));
    if (inst_ecall)       cause_d = CAUSE_ECALL;
    else if (inst_ebreak) cause_d = CAUSE_EBREAK;
    else                  cause_d = CAUSE_M_EXT_INT;
  end

  always_comb begin
    trap_target = {csr_mtvec[31:2], 2'b00};
    if (MTVEC_VECTORED && cause_q[31])
      trap_target = trap_target + {cause_q[29:0], 2'b00};
  end

  always_comb begin
    state_d         = state_q;
    csr_we_clint    = 1'b0;
    csr_waddr_clint = '0;
    csr_wdata_clint = '0;
    stall_clint     = 1'b1;
    jump_flag       = 1'b0;
    jump_addr       = '0;
    case (state_q)
      IDLE: begin
        stall_clint = accept;
        if (accept) state_d = inst_mret ? W_MRET : W_MEPC;
      end
      W_MEPC: begin
        csr_we_clint    = 1'b1;
        csr_waddr_clint = CSR_MEPC;
        csr_wdata_clint = pc_q;
        state_d         = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_we_clint    = 1'b1;
        csr_waddr_clint = CSR_MCAUSE;
        csr_wdata_clint = cause_q;
        state_d         = W_MSTATUS;
      end
      W_MSTATUS: begin
        csr_we_clint    = 1'b1;
        csr_waddr_clint = CSR_MSTATUS;
        csr_wdata_clint = mstatus_trap(csr_mstatus);
        state_d         = JUMP;
      end
      W_MRET: begin
        csr_we_clint    = 1'b1;
        csr_waddr_clint = CSR_MSTATUS;
        csr_wdata_clint = mstatus_mret(csr_mstatus);
        state_d         = JUMP;
      end
      JUMP: begin
        jump_flag = 1'b1;
        jump_addr = ret_q ? csr_mepc : trap_target;
        state_d   = IDLE;
      end
      default: begin
        stall_clint = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q  <= id_pc;
        ret_q <= inst_mret;
        if (!inst_mret) cause_q <= cause_d;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{csr_mtvec[1:0], cause_q[30]};

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a queue-based plan model checked every cycle, a small
// CSR file fed by the DUT's writes, and hand-computed literal pins.
module tb_clint;
  import clint_pkg::*;

  localparam bit VEC = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic        inst_ecall = 1'b0, inst_ebreak = 1'b0, inst_mret = 1'b0;
  logic        irq_external = 1'b0, ex_csr_we = 1'b0;
  logic [31:0] mtvec = '0, mepc = '0, mstatus = '0, mcause = '0;
  logic        gie;

  logic                         csr_we_clint;
  logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr_clint;
  logic [31:0]                  csr_wdata_clint;
  logic                         stall_clint, jump_flag;
  logic [31:0]                  jump_addr;

  assign gie = mstatus[3];

  always #5 clk = ~clk;

  clint #(.MTVEC_VECTORED(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak), .inst_mret(inst_mret),
    .irq_external(irq_external), .ex_csr_we(ex_csr_we),
    .csr_mtvec(mtvec), .csr_mepc(mepc), .csr_mstatus(mstatus),
    .global_interrupt_enable(gie),
    .csr_we_clint(csr_we_clint), .csr_waddr_clint(csr_waddr_clint),
    .csr_wdata_clint(csr_wdata_clint), .stall_clint(stall_clint),
    .jump_flag(jump_flag), .jump_addr(jump_addr)
  );

  typedef enum int {A_MEPC, A_MCAUSE, A_MST_T, A_MST_R, A_JMP_T, A_JMP_R} act_e;
  act_e        plan[$];
  logic [31:0] m_pc = '0, m_cause = '0;
  int          n_cmp = 0, n_fail = 0;

  logic                         s_stall, s_we, s_jf;
  logic [CSR_ADDRESS_WIDTH-1:0] s_wa;
  logic [31:0]                  s_wd, s_ja;

  // Expected outputs: a pending plan of actions dictates this cycle; otherwise an
  // accepted trigger stalls and enqueues the whole sequence it implies.
  task automatic model_check();
    logic                         e_stall, e_we, e_jf;
    logic [CSR_ADDRESS_WIDTH-1:0] e_wa;
    logic [31:0]                  e_wd, e_ja;
    e_stall = 0; e_we = 0; e_jf = 0; e_wa = '0; e_wd = '0; e_ja = '0;
    s_stall = stall_clint; s_we = csr_we_clint; s_wa = csr_waddr_clint;
    s_wd = csr_wdata_clint; s_jf = jump_flag; s_ja = jump_addr;
    if (plan.size() != 0) begin
      e_stall = 1;
      case (plan[0])
        A_MEPC:   begin e_we = 1; e_wa = CSR_MEPC;    e_wd = m_pc; end
        A_MCAUSE: begin e_we = 1; e_wa = CSR_MCAUSE;  e_wd = m_cause; end
        A_MST_T:  begin e_we = 1; e_wa = CSR_MSTATUS;
                        e_wd = (mstatus & ~32'h1888) | (((mstatus >> 3) & 1) << 7) | 32'h1800; end
        A_MST_R:  begin e_we = 1; e_wa = CSR_MSTATUS;
                        e_wd = (mstatus & ~32'h88) | 32'h80 | (((mstatus >> 7) & 1) << 3); end
        A_JMP_T:  begin e_jf = 1;
                        e_ja = (mtvec & ~32'h3) +
                               ((VEC && m_cause[31]) ? 4 * (m_cause & 32'h7fff_ffff) : 32'h0); end
        A_JMP_R:  begin e_jf = 1; e_ja = mepc; end
        default:  ;
      endcase
      void'(plan.pop_front());
    end else if (rst_n && id_valid && !ex_csr_we &&
                 (inst_mret || inst_ecall || inst_ebreak || (irq_external && gie))) begin
      e_stall = 1;
      m_pc = id_pc;
      if (inst_mret) begin
        plan.push_back(A_MST_R); plan.push_back(A_JMP_R);
      end else begin
        m_cause = inst_ecall ? 32'd11 : inst_ebreak ? 32'd3 : 32'h8000_000B;
        plan.push_back(A_MEPC); plan.push_back(A_MCAUSE);
        plan.push_back(A_MST_T); plan.push_back(A_JMP_T);
      end
    end
    if (!rst_n) plan.delete();
    n_cmp++;
    if ({s_stall, s_we, s_wa, s_wd, s_jf, s_ja} !== {e_stall, e_we, e_wa, e_wd, e_jf, e_ja}) begin
      n_fail++;
      $display("FAIL model t=%0t got stall=%b we=%b wa=%h wd=%h jf=%b ja=%h want stall=%b we=%b wa=%h wd=%h jf=%b ja=%h",
               $time, s_stall, s_we, s_wa, s_wd, s_jf, s_ja, e_stall, e_we, e_wa, e_wd, e_jf, e_ja);
    end
  endtask

  // One cycle: check at negedge, then let the CSR file absorb the DUT write.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    if (s_we) begin
      case (s_wa)
        CSR_MEPC:    mepc    = s_wd;
        CSR_MCAUSE:  mcause  = s_wd;
        CSR_MSTATUS: mstatus = s_wd;
        CSR_MTVEC:   mtvec   = s_wd;
        default: ;
      endcase
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  initial begin
    tick(); tick();
    pin("reset_stall", 32'(s_stall), 0);
    pin("reset_outs", 32'({s_we, s_jf}) | s_wd | s_ja | 32'(s_wa), 0);
    rst_n = 1;

    // ecall trap entry
    mtvec = 32'h100; mstatus = 32'h8; id_valid = 1; id_pc = 32'h40; inst_ecall = 1;
    tick(); pin("ecall_c0_stall", 32'(s_stall), 1); pin("ecall_c0_we", 32'(s_we), 0);
    inst_ecall = 0;
    tick(); pin("ecall_mepc_addr", 32'(s_wa), 32'h341); pin("ecall_mepc", s_wd, 32'h40);
    tick(); pin("ecall_mcause", s_wd, 32'd11);
    tick(); pin("ecall_mstatus", s_wd, 32'h1880);
    tick(); pin("ecall_jf", 32'(s_jf), 1); pin("ecall_ja", s_ja, 32'h100); pin("ecall_c4_stall", 32'(s_stall), 1);
    tick(); pin("ecall_c5_stall", 32'(s_stall), 0);

    // mret
    mepc = 32'h44; inst_mret = 1;
    tick(); pin("mret_c0_stall", 32'(s_stall), 1);
    inst_mret = 0;
    tick(); pin("mret_mstatus", s_wd, 32'h1888);
    tick(); pin("mret_ja", s_ja, 32'h44);
    tick();

    // vectored external interrupt, irq held high throughout
    mtvec = 32'h201; id_pc = 32'h80; irq_external = 1;
    tick(); tick(); pin("irq_mepc", s_wd, 32'h80);
    tick(); pin("irq_mcause", s_wd, 32'h8000_000B);
    tick(); pin("irq_mstatus", s_wd, 32'h1880);
    tick(); pin("irq_ja", s_ja, 32'h22C);
    repeat (3) tick();
    pin("irq_not_retaken", 32'(s_stall), 0);

    // irq with MIE=0 does nothing
    repeat (3) tick();
    pin("irq_mie0_we", 32'(s_we), 0);
    irq_external = 0;

    // ecall deferred by EX CSR write
    mtvec = 32'h100; mstatus = 32'h8; id_pc = 32'h48; inst_ecall = 1; ex_csr_we = 1;
    tick(); pin("defer_c0", 32'(s_stall), 0);
    tick(); pin("defer_c1", 32'({s_stall, s_we}), 0);
    ex_csr_we = 0;
    tick(); pin("defer_accept", 32'(s_stall), 1);
    inst_ecall = 0;
    tick(); pin("defer_mepc", s_wd, 32'h48);
    tick(); tick(); tick(); pin("defer_ja", s_ja, 32'h100);
    tick();

    // ecall wins over irq; irq stays pending but MIE=0 blocks retake
    mstatus = 32'h8; id_pc = 32'h4c; inst_ecall = 1; irq_external = 1;
    tick(); inst_ecall = 0;
    tick(); tick(); pin("prio_mcause", s_wd, 32'd11);
    tick(); tick();
    repeat (4) tick();
    pin("prio_idle", 32'(s_stall), 0);
    irq_external = 0;

    // mret beats ecall
    mepc = 32'h90; mstatus = 32'h1880; inst_mret = 1; inst_ecall = 1;
    tick(); inst_mret = 0; inst_ecall = 0;
    tick(); pin("mret_prio_addr", 32'(s_wa), 32'h300); pin("mret_prio_wd", s_wd, 32'h1888);
    tick(); pin("mret_prio_ja", s_ja, 32'h90);
    tick();

    // ebreak
    mstatus = 32'h8; id_pc = 32'h60; inst_ebreak = 1;
    tick(); inst_ebreak = 0;
    tick(); tick(); pin("ebreak_mcause", s_wd, 32'd3);
    tick(); tick(); tick();

    // bubble in ID is never trapped
    id_valid = 0; inst_ecall = 1;
    tick(); pin("bubble_stall", 32'(s_stall), 0);
    inst_ecall = 0; id_valid = 1;

    // reset during W_MCAUSE aborts the sequence
    mstatus = 32'h8; id_pc = 32'h70; inst_ecall = 1;
    tick(); inst_ecall = 0;
    tick();
    rst_n = 0;
    tick(); pin("rst_mcause_cycle", s_wd, 32'd11);
    rst_n = 1;
    tick(); pin("rst_after", 32'({s_stall, s_we, s_jf}), 0);
    repeat (4) tick();
    pin("rst_no_jump", 32'(s_jf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clint.md
# clint

Core-local interrupt controller for the pipelined RV32I core. Sits beside the CSR file, consuming its `mtvec`/`mepc`/`mstatus`/`global_interrupt_enable` outputs and driving its `csr_*_clint` write port. Detects `ecall`/`ebreak`/`mret` decoded in ID and a level external interrupt, then sequences the trap-entry or trap-return CSR updates one register per cycle. While sequencing it stalls the pipeline and finishes with a single-cycle redirect to IF.

## Interface
Parameters:
- `MTVEC_VECTORED`, default 0: when 1, interrupts jump to `{mtvec[31:2],2'b00} + 4*cause[30:0]`; exceptions always go to the base address.

Ports:
- Reset is `rst_n`, synchronous, active-low; clock is `clk`.
- `clk`  in  1  core clock
- `rst_n`  in  1  synchronous active-low reset
- `id_valid`  in  1  ID holds a real (non-bubble) instruction
- `id_pc`  in  32  PC of the ID instruction
- `inst_ecall` / `inst_ebreak` / `inst_mret`  in  1 each  decode flags for the ID instruction
- `irq_external`  in  1  external interrupt request, level, already synchronised
- `ex_csr_we`  in  1  EX stage is writing a CSR this cycle
- `csr_mtvec`, `csr_mepc`, `csr_mstatus`  in  32 each  from csr
- `global_interrupt_enable`  in  1  `mstatus.MIE`, from csr
- `csr_we_clint`  out  1  CSR write strobe
- `csr_waddr_clint`  out  `CSR_ADDRESS_WIDTH`  CSR write address
- `csr_wdata_clint`  out  32  CSR write data
- `stall_clint`  out  1  freeze IF/ID and inject a bubble into EX
- `jump_flag`  out  1  redirect and flush request, one cycle
- `jump_addr`  out  32  redirect target

## Operation
- States: `IDLE`, `W_MEPC`, `W_MCAUSE`, `W_MSTATUS`, `W_MRET`, `JUMP`.
- Triggers are evaluated only in `IDLE` with `id_valid=1` and `ex_csr_we=0`. If `ex_csr_we=1`, the trigger is deferred (no latch, no stall) and re-evaluated next cycle.
- Trigger priority: `inst_mret` > `inst_ecall` > `inst_ebreak` > interrupt (`irq_external & global_interrupt_enable`).
- On an accepted trigger: latch `pc_q=id_pc` and `cause_q`.
  - Cause values: ecall 32'd11, ebreak 32'd3, interrupt 32'h8000_000B.
  - For an interrupt, the ID instruction is killed and re-executed after `mret`, so `mepc` = its PC.
- Trap path: `IDLE`→`W_MEPC`→`W_MCAUSE`→`W_MSTATUS`→`JUMP`→`IDLE`.
  - `W_MEPC` writes `pc_q` to `CSR_MEPC`.
  - `W_MCAUSE` writes `cause_q` to `CSR_MCAUSE`.
  - `W_MSTATUS` writes `csr_mstatus` with bit7 (MPIE)=bit3, bit3 (MIE)=0, bits12:11 (MPP)=2'b11.
  - `JUMP` target is `{csr_mtvec[31:2],2'b00}`, plus the vectored offset for interrupts when `MTVEC_VECTORED=1`.
- Return path: `IDLE`→`W_MRET`→`JUMP`→`IDLE`.
  - `W_MRET` writes `csr_mstatus` with bit3=bit7 and bit7=1.
  - `JUMP` target is `csr_mepc`.
- `csr_we_clint` is high exactly in the `W_*` states; address and data are 0 otherwise.
- A new trigger is not evaluated in `JUMP`; the earliest new trigger is the cycle after `JUMP`.
- An interrupt asserted during a trap sequence is ignored. After entry, MIE=0 blocks it until `mret`.

## Timing
- Reset values: state=`IDLE`; all outputs 0; `pc_q`, `cause_q` = 0.
- Reset asserted mid-sequence aborts the sequence: next cycle is `IDLE` and all outputs are 0. CSR writes already performed stay.
- `stall_clint` is combinational: high in the accept cycle in `IDLE`, and in every non-`IDLE` state including `JUMP`.
- Trap latency: accept at cycle 0, `mepc` write at cycle 1, `mcause` at 2, `mstatus` at 3, `jump_flag` at 4, `IDLE` at 5.
- `mret` latency: accept at 0, `mstatus` write at 1, `jump_flag` at 2.
- `jump_flag` is high for exactly one cycle. `jump_addr` is valid only while `jump_flag=1` and is 0 otherwise.
- CSR values are sampled combinationally from csr in the cycle they are used. Each write lands at the end of its cycle and is visible to the next state.

## Structure
- Add to the shared `defines.v`: cause codes (`CAUSE_ECALL`, `CAUSE_EBREAK`, `CAUSE_M_EXT_INT`) and `mstatus` bit indices (MIE=3, MPIE=7, MPP=12:11). `CSR_*` addresses and `CSR_ADDRESS_WIDTH` already live there.
- State encoding stays local as `localparam`s.
- Single module, no sub-module.

## Test plan
- `ecall` at `id_pc`=0x40, `mtvec`=0x100, `mstatus`=0x8 → writes `mepc`=0x40, `mcause`=11, `mstatus`=0x1880 on cycles 1-3; `jump_flag` at cycle 4 with `jump_addr`=0x100; `stall_clint` high for cycles 0-4.
- `mret` with `mepc`=0x44, `mstatus`=0x1880 → `mstatus` written 0x1888 at cycle 1; jump to 0x44 at cycle 2.
- `irq_external`=1 with MIE=1, `id_pc`=0x80, `MTVEC_VECTORED`=1, `mtvec`=0x201 → `mcause`=0x8000000B; jump to 0x22C. The same irq with MIE=0 → no activity.
- `ecall` coincident with `ex_csr_we`=1 for 2 cycles → no stall or write for those cycles; acceptance on the 3rd cycle, then the normal trap sequence.
- `ecall` and `irq_external` asserted together with MIE=1 → `mcause`=11; the irq stays pending, is not retaken, and 0x8000000B is never written.
- `rst_n`=0 while in `W_MCAUSE` → next cycle `IDLE`, all outputs 0, no `jump_flag`.
